// File: rtl/clock_set_ctrl_pkg.sv
// Shared constants and state encoding for the time-of-day set controller.
package clock_pkg;

    localparam logic [1:0] MODE_RUN    = 2'd0;
    localparam logic [1:0] MODE_SET_HH = 2'd1;
    localparam logic [1:0] MODE_SET_MM = 2'd2;
    localparam logic [1:0] MODE_SET_SS = 2'd3;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;

    typedef enum logic [1:0] {
        ST_RUN    = MODE_RUN,
        ST_SET_HH = MODE_SET_HH,
        ST_SET_MM = MODE_SET_MM,
        ST_SET_SS = MODE_SET_SS
    } state_t;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Strobes, buttons and time/display outputs of the set controller.
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic              tick;
    logic              tick_blink;
    logic              btn_mode;
    logic              btn_inc;
    logic              btn_dec;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [1:0]        mode;
    logic              blank_hour;
    logic              blank_min;
    logic              blank_sec;
    logic              day_pulse;

    modport slave (
        input  tick, tick_blink, btn_mode, btn_inc, btn_dec,
        output hour, min, sec, mode, blank_hour, blank_min, blank_sec, day_pulse
    );

    modport master (
        output tick, tick_blink, btn_mode, btn_inc, btn_dec,
        input  hour, min, sec, mode, blank_hour, blank_min, blank_sec, day_pulse
    );

endinterface

// File: rtl/clock_set_ctrl_wrap_counter.sv
// Modulo-(MAX+1) up/down counter; wrap_up flags the MAX->0 increment combinationally
// so the caller can chain carries on the same edge.
module wrap_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         up,
    input  logic         dn,
    output logic [W-1:0] q,
    output logic         wrap_up
);

    assign wrap_up = up & ~dn & (q == W'(MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= load_val;
        end else if (load) begin
            q <= load_val;
        end else if (up && !dn) begin
            q <= (q == W'(MAX)) ? '0 : q + 1'b1;
        end else if (dn && !up) begin
            q <= (q == '0) ? W'(MAX) : q - 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// RUN/SET mode controller for hh:mm:ss: advances on tick, edits one field with
// inc/dec while frozen, blinks the edited field and auto-returns to RUN on idle.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 30,
    parameter int RESET_HOUR    = 0,
    parameter int RESET_MIN     = 0
) (
    input logic             clk,
    input logic             rst,
    clock_set_ctrl_if.slave bus
);

    localparam int CNT_W   = $clog2(TIMEOUT_TICKS + 2);
    localparam int TO_LAST = (TIMEOUT_TICKS == 0) ? 0 : TIMEOUT_TICKS - 1;

    state_t           state, state_n;
    logic             mode_q, inc_q, dec_q;
    logic             p_mode, p_inc, p_dec, any_press, inc_e, dec_e;
    logic [CNT_W-1:0] to_cnt;
    logic             to_hit, mode_chg, phase, phase_n;
    logic             run, in_hh, in_mm, in_ss;
    logic             sec_wrap, min_wrap, hour_wrap;

    assign p_mode    = bus.btn_mode & ~mode_q;
    assign p_inc     = bus.btn_inc & ~inc_q;
    assign p_dec     = bus.btn_dec & ~dec_q;
    assign any_press = p_mode | p_inc | p_dec;
    // mode press wins; inc+dec together cancel
    assign inc_e     = p_inc & ~p_dec & ~p_mode;
    assign dec_e     = p_dec & ~p_inc & ~p_mode;

    assign run   = (state == ST_RUN);
    assign in_hh = (state == ST_SET_HH);
    assign in_mm = (state == ST_SET_MM);
    assign in_ss = (state == ST_SET_SS);

    assign to_hit = (TIMEOUT_TICKS != 0) && !run && bus.tick && !any_press
                    && (to_cnt == CNT_W'(TO_LAST));

    always_comb begin
        state_n = state;
        if (p_mode) begin
            case (state)
                ST_RUN:    state_n = ST_SET_HH;
                ST_SET_HH: state_n = ST_SET_MM;
                ST_SET_MM: state_n = ST_SET_SS;
                default:   state_n = ST_RUN;
            endcase
        end else if (to_hit) begin
            state_n = ST_RUN;
        end
    end

    assign mode_chg = (state_n != state);

    always_comb begin
        phase_n = phase;
        if (mode_chg || p_inc || p_dec) phase_n = 1'b0;
        else if (bus.tick_blink)        phase_n = ~phase;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q         <= 1'b0;
            inc_q          <= 1'b0;
            dec_q          <= 1'b0;
            state          <= ST_RUN;
            to_cnt         <= '0;
            phase          <= 1'b0;
            bus.blank_hour <= 1'b0;
            bus.blank_min  <= 1'b0;
            bus.blank_sec  <= 1'b0;
            bus.day_pulse  <= 1'b0;
        end else begin
            mode_q         <= bus.btn_mode;
            inc_q          <= bus.btn_inc;
            dec_q          <= bus.btn_dec;
            state          <= state_n;
            phase          <= phase_n;
            // blanks track the registered mode/phase pair
            bus.blank_hour <= (state_n == ST_SET_HH) & phase_n;
            bus.blank_min  <= (state_n == ST_SET_MM) & phase_n;
            bus.blank_sec  <= (state_n == ST_SET_SS) & phase_n;
            bus.day_pulse  <= run & hour_wrap;
            if (any_press || mode_chg)   to_cnt <= '0;
            else if (!run && bus.tick)   to_cnt <= to_cnt + 1'b1;
        end
    end

    assign bus.mode = state;

    // carries only ripple in RUN; set edits wrap a field in isolation
    wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
        .up((run & bus.tick) | (in_ss & inc_e)), .dn(in_ss & dec_e),
        .q(bus.sec), .wrap_up(sec_wrap)
    );

    wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .load(1'b0), .load_val(MIN_W'(RESET_MIN)),
        .up((run & sec_wrap) | (in_mm & inc_e)), .dn(in_mm & dec_e),
        .q(bus.min), .wrap_up(min_wrap)
    );

    wrap_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .load(1'b0), .load_val(HOUR_W'(RESET_HOUR)),
        .up((run & min_wrap) | (in_hh & inc_e)), .dn(in_hh & dec_e),
        .q(bus.hour), .wrap_up(hour_wrap)
    );

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed + random bench for clock_set_ctrl against a seconds-of-day reference model.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(.TIMEOUT_TICKS(3), .RESET_HOUR(23), .RESET_MIN(59)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference state: time as seconds since midnight
    int   tod, m_mode, m_cnt, m_phase, m_dp;
    logic bm_q, bi_q, bd_q;

    task automatic model_reset();
        tod = 23 * 3600 + 59 * 60;
        m_mode = 0; m_cnt = 0; m_phase = 0; m_dp = 0;
        bm_q = 1'b0; bi_q = 1'b0; bd_q = 1'b0;
    endtask

    task automatic model_step(input logic m, input logic i, input logic d,
                              input logic t, input logic b);
        logic pm, pi, pd;
        int h, mi, s, delta, prev_mode;
        pm = m & ~bm_q; pi = i & ~bi_q; pd = d & ~bd_q;
        bm_q = m; bi_q = i; bd_q = d;
        m_dp = 0;
        prev_mode = m_mode;
        if (m_mode == 0) begin
            if (t) begin
                tod = (tod + 1) % 86400;
                m_dp = (tod == 0) ? 1 : 0;
            end
        end else if (!pm && (pi ^ pd)) begin
            h = tod / 3600; mi = (tod / 60) % 60; s = tod % 60;
            delta = pi ? 1 : -1;
            case (m_mode)
                1:       h  = (h + delta + 24) % 24;
                2:       mi = (mi + delta + 60) % 60;
                default: s  = (s + delta + 60) % 60;
            endcase
            tod = h * 3600 + mi * 60 + s;
        end
        if (pm) begin
            m_mode = (m_mode + 1) % 4;
            m_cnt = 0;
        end else if (m_mode != 0) begin
            if (pi || pd) m_cnt = 0;
            else if (t) begin
                m_cnt++;
                if (m_cnt == 3) begin m_mode = 0; m_cnt = 0; end
            end
        end
        if (m_mode != prev_mode || pi || pd) m_phase = 0;
        else if (b) m_phase = m_phase ^ 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all();
        chk("hour", 32'(bus.hour), tod / 3600);
        chk("min", 32'(bus.min), (tod / 60) % 60);
        chk("sec", 32'(bus.sec), tod % 60);
        chk("mode", 32'(bus.mode), m_mode);
        chk("blank_hour", 32'(bus.blank_hour), (m_mode == 1 && m_phase == 1) ? 1 : 0);
        chk("blank_min", 32'(bus.blank_min), (m_mode == 2 && m_phase == 1) ? 1 : 0);
        chk("blank_sec", 32'(bus.blank_sec), (m_mode == 3 && m_phase == 1) ? 1 : 0);
        chk("day_pulse", 32'(bus.day_pulse), m_dp);
    endtask

    task automatic step(input logic m, input logic i, input logic d);
        logic t, b;
        t = (cyc % 10 == 9);
        b = (cyc % 5 == 4);
        bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d;
        bus.tick = t; bus.tick_blink = b;
        @(posedge clk);
        model_step(m, i, d, t, b);
        cyc++;
        #1;
        check_all();
    endtask

    // press and release, kept clear of tick cycles so the idle count is predictable
    task automatic press(input logic m, input logic i, input logic d);
        while ((cyc % 10) >= 8) step(1'b0, 1'b0, 1'b0);
        step(m, i, d);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic goto_mode(input int target);
        for (int k = 0; k < 4 && m_mode != target; k++) press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_tick();
        logic t;
        do begin
            t = (cyc % 10 == 9);
            step(1'b0, 1'b0, 1'b0);
        end while (!t);
    endtask

    initial begin
        int dpc, h0, mn0, s0, r;
        bus.tick = 1'b0; bus.tick_blink = 1'b0;
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("rst_hour", 32'(bus.hour), 23);
        chk("rst_min", 32'(bus.min), 59);
        #1 rst = 1'b1;

        // 1: run through midnight
        dpc = 0;
        repeat (590) begin step(1'b0, 1'b0, 1'b0); if (bus.day_pulse === 1'b1) dpc++; end
        chk("t1_pre_h", 32'(bus.hour), 23);
        chk("t1_pre_m", 32'(bus.min), 59);
        chk("t1_pre_s", 32'(bus.sec), 59);
        repeat (10) begin step(1'b0, 1'b0, 1'b0); if (bus.day_pulse === 1'b1) dpc++; end
        chk("t1_h", 32'(bus.hour), 0);
        chk("t1_m", 32'(bus.min), 0);
        chk("t1_s", 32'(bus.sec), 0);
        chk("t1_daypulses", 32'(dpc), 1);

        // 2: hour edit wraps both ways, time frozen
        press(1'b1, 1'b0, 1'b0);
        chk("t2_mode", 32'(bus.mode), 1);
        repeat (25) press(1'b0, 1'b1, 1'b0);
        chk("t2_inc25", 32'(bus.hour), 1);
        chk("t2_sec_frozen", 32'(bus.sec), 0);
        repeat (2) press(1'b0, 1'b0, 1'b1);
        chk("t2_dec2", 32'(bus.hour), 23);

        // 3: minute wrap without carry; held button is one press
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("t3_min59", 32'(bus.min), 59);
        press(1'b0, 1'b1, 1'b0);
        chk("t3_min_wrap", 32'(bus.min), 0);
        chk("t3_hour_kept", 32'(bus.hour), 23);
        repeat (50) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_held_once", 32'(bus.min), 1);

        // 4: seconds blink, inc press forces field visible
        goto_mode(3);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6 && m_phase != 1; k++) step(1'b0, 1'b0, 1'b0);
        chk("t4_blank_on", 32'(bus.blank_sec), 1);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_blank_off", 32'(bus.blank_sec), 0);
        step(1'b0, 1'b0, 1'b0);

        // 5: timeout after 3 idle ticks, restarted by a press
        goto_mode(1);
        wait_tick(); wait_tick();
        chk("t5_mode_2ticks", 32'(bus.mode), 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        wait_tick(); wait_tick();
        chk("t5_mode_restart", 32'(bus.mode), 1);
        wait_tick();
        chk("t5_timeout", 32'(bus.mode), 0);
        s0 = tod % 60;
        wait_tick();
        chk("t5_resume", 32'(bus.sec), (s0 + 1) % 60);

        // 6: simultaneous presses and async reset
        goto_mode(1);
        h0 = tod / 3600;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_mode_wins", 32'(bus.mode), 2);
        chk("t6_hour_same", 32'(bus.hour), h0);
        mn0 = (tod / 60) % 60;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_incdec_drop", 32'(bus.min), mn0);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_async_mode", 32'(bus.mode), 0);
        #1 rst = 1'b1;

        // random button traffic
        repeat (3000) begin
            r = $urandom_range(0, 15);
            step(r == 0, r inside {1, 2, 3}, r inside {3, 4, 5});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
